gcd_lcm_coproc: RTL

//  Responder end of the GCD/LCM command word built by the core's operand-packing ALUs.

---
 rtl/gcd_lcm_coproc.sv | 102 ++++++++++
 1 files changed

// File: rtl/gcd_lcm_coproc.sv
// gcd_lcm_coproc: iterative GCD/LCM responder for a packed {op, y, x} command word.
// Ports: clk, reset (async, active-low); cmd_valid/cmd_ready/cmd_word command channel;
// rsp_valid/rsp_ready/rsp_data response channel (zero-extended result); busy from accept to handshake.
module gcd_lcm_coproc #(
  parameter int WIDTH  = 8,
  parameter int OP_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_word,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy
);
  localparam int RW = 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic op_q, op_d, init_q, init_d;
  logic cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, busy_q, busy_d;
  logic [RW-1:0] x_q, x_d, y_q, y_d, a_q, a_d, b_q, b_d, res_q, res_d;
  logic unused_hi;
  assign unused_hi = ^cmd_word[31:OP_BIT+1];
  // a/b double as the GCD pair (a, b) and the LCM running multiples (m, n);
  // init_q marks the first RUN cycle, which screens zero operands and loads a/b.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    init_d  = init_q;
    x_d     = x_q;
    y_d     = y_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        op_d    = cmd_word[OP_BIT];
        x_d     = RW'(cmd_word[WIDTH-1:0]);
        y_d     = RW'(cmd_word[RW-1:WIDTH]);
        init_d  = 1'b1;
        state_d = RUN;
      end
      RUN: if (init_q) begin
        init_d = 1'b0;
        if (x_q == '0 || y_q == '0) begin
          res_d   = op_q ? '0 : (x_q | y_q);
          state_d = DONE;
        end else begin
          a_d = x_q;
          b_d = y_q;
        end
      end else if (a_q == b_q) begin
        res_d   = a_q;
        state_d = DONE;
      end else if (op_q) begin
        a_d = (a_q < b_q) ? a_q + x_q : a_q;
        b_d = (a_q < b_q) ? b_q : b_q + y_q;
      end else begin
        a_d = (a_q > b_q) ? a_q - b_q : a_q;
        b_d = (a_q > b_q) ? b_q : b_q - a_q;
      end
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= 1'b0;
      init_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      init_q      <= init_d;
      x_q         <= x_d;
      y_q         <= y_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;
  assign rsp_data  = 32'(res_q);
endmodule
